uart_tx_arbiter: RTL

Shares the single UART frame sender (EB 9C header + 8 payload bytes) among `N_REQ` producers, for example AD status, temperature and DAC parameter reports. It sits between the producers and the frame sender. It grants one 64-bit payload at a time in round-robin order, drives the sender's valid/ready pair, and holds the payload stable for the whole frame. It also flags a sender that never starts a frame.

---
 rtl/uart_tx_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART frame-sender arbiter slice.
// Contents: arbiter FSM state type, frame header bytes, payload width.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  localparam logic [7:0]  FRAME_HDR0 = 8'hEB;
  localparam logic [7:0]  FRAME_HDR1 = 8'h9C;
  localparam int unsigned PAYLOAD_W  = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
// Ports:
//   req_i  - request vector
//   ptr_i  - index where the search starts
//   gnt_o  - one-hot grant (all zero when no request)
//   idx_o  - encoded index of the granted request (0 when none)
module rr_arbiter
  import uart_tx_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o
);

  logic          found;
  logic [IW-1:0] k;

  // Scan from ptr_i upward, wrapping past N_REQ-1; first set bit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = IW'((32'(ptr_i) + i) % N_REQ);
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART frame sender among N_REQ producers.
// Grants one payload at a time, drives the sender valid/ready pair, holds
// the payload stable for the whole frame and flags a sender that never
// goes busy after issue.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   req_valid/req_data    - per-requester pending flag and payload slice
//   req_ready             - one-hot accept (combinational, IDLE only)
//   fs_ready              - frame sender idle
//   fs_valid/fs_data      - payload handed to the frame sender
//   grant_id              - index of the requester being served
//   busy                  - arbiter not idle
//   err_timeout           - one-cycle pulse when the sender never went busy
//   frame_cnt             - frames completed (wraps)
module uart_tx_arbiter
  import uart_tx_pkg::*;
#(
  parameter  int unsigned N_REQ   = 4,
  parameter  int unsigned DATA_W  = PAYLOAD_W,
  parameter  int unsigned BUSY_TO = 16,
  localparam int unsigned IW      = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    fs_ready,
  output logic                    fs_valid,
  output logic [DATA_W-1:0]       fs_data,
  output logic [IW-1:0]           grant_id,
  output logic                    busy,
  output logic                    err_timeout,
  output logic [15:0]             frame_cnt
);

  localparam int unsigned TO_W = $clog2(BUSY_TO + 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     grant_id_q, grant_id_d;
  logic [DATA_W-1:0] fs_data_q, fs_data_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              err_q, err_d;

  logic [N_REQ-1:0]  win_gnt;
  logic [IW-1:0]     win_idx;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      fs_data_q   <= '0;
      to_cnt_q    <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      fs_data_q   <= fs_data_d;
      to_cnt_q    <= to_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  // to_cnt is zeroed at accept and counts every fs_valid cycle (ISSUE
  // included), so reaching BUSY_TO-1 in WAIT_BUSY means fs_valid has been
  // high for exactly BUSY_TO cycles.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    fs_data_d   = fs_data_q;
    to_cnt_d    = to_cnt_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = 1'b0;
    req_ready   = '0;
    fs_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fs_ready && (|req_valid)) begin
          req_ready  = rst ? '0 : win_gnt;
          fs_data_d  = req_data[win_idx*DATA_W +: DATA_W];
          grant_id_d = win_idx;
          rr_ptr_d   = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);
          to_cnt_d   = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        fs_valid = 1'b1;
        to_cnt_d = to_cnt_q + TO_W'(1);
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        fs_valid = 1'b1;
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (!fs_ready) begin
          state_d = WAIT_DONE;
        end else if (to_cnt_q == TO_W'(BUSY_TO - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (fs_ready) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fs_data     = fs_data_q;
  assign grant_id    = grant_id_q;
  assign busy        = (state_q != IDLE);
  assign err_timeout = err_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
